// File: rtl/cnu_layer_iter_sched.sv
// Layer/iteration sequencer around cnu_control_unit: counts write-back pages, pulses layer_finish/iter_done, raises termination.
// Optional early termination on a zero syndrome is compiled in with `define EARLY_TERMINATION_EN.
module cnu_layer_iter_sched #(
  parameter int LAYER_NUM   = 3,
  parameter int MAX_ITER    = 10,
  parameter int WB_PAGE_NUM = 4,
  parameter int LAYER_W     = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1,
  parameter int ITER_W      = $clog2(MAX_ITER + 1)
) (
  input  logic               read_clk,
  input  logic               rstn,
  input  logic               fsm_en,
  input  logic               c2v_mem_we,
  input  logic               syndrome_valid,
  input  logic               syndrome_zero,
  output logic               layer_finish,
  output logic               termination,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic               iter_done,
  output logic               wb_overrun,
  output logic               busy
);
  localparam int WB_W = (WB_PAGE_NUM > 1) ? $clog2(WB_PAGE_NUM) : 1;

  typedef enum logic [1:0] {IDLE, RUN, LAYER_END, TERM} state_e;

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [WB_W-1:0]    wb_q, wb_d;
  logic               ovr_q, ovr_d;
  logic               et_q, et_d;
  logic               last_layer;

  assign last_layer = (layer_q == LAYER_W'(LAYER_NUM - 1));

  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      layer_q <= '0;
      iter_q  <= '0;
      wb_q    <= '0;
      ovr_q   <= 1'b0;
      et_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      iter_q  <= iter_d;
      wb_q    <= wb_d;
      ovr_q   <= ovr_d;
      et_q    <= et_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    iter_d  = iter_q;
    wb_d    = wb_q;
    ovr_d   = ovr_q;
    et_d    = et_q;
    case (state_q)
      IDLE: if (fsm_en) state_d = RUN;
      // fsm_en low in RUN is a pause: strobes are dropped without flagging overrun
      RUN: begin
        if (fsm_en && c2v_mem_we) begin
          if (wb_q == WB_W'(WB_PAGE_NUM - 1)) begin
            wb_d    = '0;
            state_d = LAYER_END;
          end else begin
            wb_d = wb_q + WB_W'(1);
          end
        end
      end
      LAYER_END: begin
        if (last_layer) begin
          layer_d = '0;
          iter_d  = iter_q + ITER_W'(1);
          state_d = ((iter_q + ITER_W'(1)) == ITER_W'(MAX_ITER) || et_q) ? TERM : RUN;
        end else begin
          layer_d = layer_q + LAYER_W'(1);
          state_d = RUN;
        end
      end
      TERM: if (!fsm_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (c2v_mem_we && (state_q != RUN)) ovr_d = 1'b1;

`ifdef EARLY_TERMINATION_EN
    if (syndrome_valid && syndrome_zero && (state_q == RUN || state_q == LAYER_END))
      et_d = 1'b1;
`else
    et_d = 1'b0;
`endif

    // a fresh decode always starts from layer 0, iteration 0
    if (state_d == IDLE) begin
      layer_d = '0;
      iter_d  = '0;
      wb_d    = '0;
      et_d    = 1'b0;
    end
  end

`ifndef EARLY_TERMINATION_EN
  logic unused_syn;
  assign unused_syn = syndrome_valid ^ syndrome_zero;
`endif

  assign layer_finish = (state_q == LAYER_END);
  assign iter_done    = layer_finish && last_layer;
  assign termination  = (state_q == TERM);
  assign busy         = (state_q != IDLE);
  assign layer_idx    = layer_q;
  assign iter_cnt     = iter_q;
  assign wb_overrun   = ovr_q;
endmodule

// File: tb/tb_cnu_layer_iter_sched.sv
// Randomized + directed bench for cnu_layer_iter_sched against a page-count reference model.
module tb_cnu_layer_iter_sched;
  localparam int L = 3, MAXI = 2, WB = 4, PER = WB * L;
`ifdef EARLY_TERMINATION_EN
  localparam int ET = 1;
`else
  localparam int ET = 0;
`endif

  logic read_clk = 1'b0, rstn = 1'b0, fsm_en = 1'b0, c2v_mem_we = 1'b0;
  logic syndrome_valid = 1'b0, syndrome_zero = 1'b0;
  logic layer_finish, termination, iter_done, wb_overrun, busy;
  logic [1:0] layer_idx, iter_cnt;

  cnu_layer_iter_sched #(.LAYER_NUM(L), .MAX_ITER(MAXI), .WB_PAGE_NUM(WB)) dut (
    .read_clk(read_clk), .rstn(rstn), .fsm_en(fsm_en), .c2v_mem_we(c2v_mem_we),
    .syndrome_valid(syndrome_valid), .syndrome_zero(syndrome_zero),
    .layer_finish(layer_finish), .termination(termination), .layer_idx(layer_idx),
    .iter_cnt(iter_cnt), .iter_done(iter_done), .wb_overrun(wb_overrun), .busy(busy));

  always #5 read_clk = ~read_clk;

  int n_chk = 0, n_fail = 0;
  // model: total accepted pages since decode start; layer/iteration derive from it
  int m_tp = 0;
  bit m_act = 0, m_term = 0, m_pulse = 0, m_ovr = 0, m_et = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit et_old;
    bit syn;
    syn = (ET != 0) && syndrome_valid && syndrome_zero;
    if (!rstn) begin
      m_tp = 0; m_act = 0; m_term = 0; m_pulse = 0; m_ovr = 0; m_et = 0;
    end else if (!m_act) begin
      if (c2v_mem_we) m_ovr = 1;
      if (fsm_en) begin m_act = 1; m_tp = 0; end
    end else if (m_term) begin
      if (c2v_mem_we) m_ovr = 1;
      if (!fsm_en) begin m_act = 0; m_term = 0; m_tp = 0; m_et = 0; end
    end else if (m_pulse) begin
      if (c2v_mem_we) m_ovr = 1;
      et_old = m_et;
      if (syn) m_et = 1;
      m_pulse = 0;
      if (m_tp % PER == 0 && (m_tp / PER == MAXI || et_old)) m_term = 1;
    end else begin
      if (syn) m_et = 1;
      if (fsm_en && c2v_mem_we) begin
        m_tp++;
        if (m_tp % WB == 0) m_pulse = 1;
      end
    end
  endtask

  task automatic check_all();
    int e_layer, e_iter;
    e_layer = m_pulse ? ((m_tp / WB) - 1) % L : (m_tp / WB) % L;
    e_iter  = m_pulse ? (m_tp - 1) / PER : m_tp / PER;
    chk("layer_finish", int'(layer_finish), int'(m_pulse));
    chk("iter_done", int'(iter_done), int'(m_pulse && (m_tp % PER == 0)));
    chk("termination", int'(termination), int'(m_term));
    chk("busy", int'(busy), int'(m_act));
    chk("wb_overrun", int'(wb_overrun), int'(m_ovr));
    chk("layer_idx", int'(layer_idx), e_layer);
    chk("iter_cnt", int'(iter_cnt), e_iter);
  endtask

  task automatic drive(input bit r, input bit f, input bit w);
    rstn = r; fsm_en = f; c2v_mem_we = w;
    @(posedge read_clk);
    model_step();
    @(negedge read_clk);
    check_all();
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 1);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) drive(0, 0, 0);
  endtask

  initial begin
    // 1: reset with live inputs, then start
    for (int i = 0; i < 5; i++) drive(0, 1, i[0]);
    chk("rst_busy", int'(busy), 0);
    drive(1, 1, 0);
    chk("start_busy", int'(busy), 1);
    // 2: one layer of back-to-back pages
    writes(4);
    chk("l0_finish", int'(layer_finish), 1);
    idles(1);
    chk("l0_pulse_len", int'(layer_finish), 0);
    chk("l0_idx", int'(layer_idx), 1);
    // 3: full run to forced termination
    do_reset();
    idles(1);
    for (int g = 0; g < 6; g++) begin writes(4); idles(3); end
    idles(2);
    chk("run_term", int'(termination), 1);
    chk("run_iter", int'(iter_cnt), MAXI);
    drive(1, 0, 0);
    chk("run_idle_busy", int'(busy), 0);
    chk("run_idle_term", int'(termination), 0);
    // 4: pause is not an overrun; write during LAYER_END is
    do_reset();
    idles(1);
    writes(2);
    for (int i = 0; i < 5; i++) drive(1, 0, 1);
    writes(2);
    chk("pause_finish", int'(layer_finish), 1);
    chk("pause_ovr", int'(wb_overrun), 0);
    writes(1);
    chk("le_ovr", int'(wb_overrun), 1);
    writes(4);
    chk("le_wb_clear", int'(layer_finish), 1);
    // 5: zero syndrome during layer 1 of iteration 0
    do_reset();
    idles(1);
    writes(4); idles(2);
    syndrome_valid = 1; syndrome_zero = 1;
    writes(1);
    syndrome_valid = 0; syndrome_zero = 0;
    writes(3); idles(2);
    writes(4);
    idles(1);
    chk("et_term", int'(termination), ET);
    idles(2);
    for (int g = 0; g < 3; g++) begin writes(4); idles(3); end
    chk("et_iter", int'(iter_cnt), ET ? 1 : 2);
    // 6: reset mid-layer
    do_reset();
    idles(1);
    writes(4); idles(1); writes(4); idles(1); writes(3);
    drive(0, 1, 0);
    chk("mid_rst_idx", int'(layer_idx), 0);
    drive(1, 1, 0);
    writes(4);
    chk("mid_rst_finish", int'(layer_finish), 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      syndrome_valid = 1'($urandom_range(0, 3) == 0);
      syndrome_zero  = 1'($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
